// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, data requester and memory-side signals of
//   the shared CPU memory port.
//   slave  : arbiter view (takes requests and m_ack/m_rdata, drives grants,
//            completions and the m_* request bus)
//   master : environment view (CPU requesters plus memory model)
interface mem_port_arbiter_if;
    // Instruction fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    // Load/store data requester
    logic        d_req;
    logic        d_rw;
    logic [3:0]  d_wstrobe;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        bus_err;
    // Memory port
    logic        m_req;
    logic        m_rw;
    logic [3:0]  m_wstrobe;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_rw, d_wstrobe, d_addr, d_wdata, m_ack, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, bus_err,
               m_req, m_rw, m_wstrobe, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_rw, d_wstrobe, d_addr, d_wdata, m_ack, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, bus_err,
               m_req, m_rw, m_wstrobe, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and load/store
//   data (D). One transaction outstanding at a time; D has priority, but
//   after MAX_DATA_STREAK back-to-back D grants with IF waiting, IF wins.
//   A transaction whose m_ack never arrives is aborted after TIMEOUT cycles
//   and completed with rdata 32'hDEADBEEF and bus_err.
// Ports
//   clk    : clock, rising edge
//   nreset : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (requesters + memory port)
// All outputs are registered.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,   // 1..15
    parameter int unsigned TIMEOUT         = 255  // 1..255
) (
    input  logic               clk,
    input  logic               nreset,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        if_gnt_q, if_gnt_d;
    logic        d_gnt_q, d_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        m_req_q, m_req_d;
    logic        m_rw_q, m_rw_d;
    logic [3:0]  m_wstrobe_q, m_wstrobe_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;

    logic        d_wins;
    logic [31:0] done_data;

    // IF only beats a pending D once the data streak has hit its limit.
    assign d_wins = bus.d_req && !(bus.if_req && (streak_q == STREAK_MAX));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        m_req_d     = m_req_q;
        m_rw_d      = m_rw_q;
        m_wstrobe_d = m_wstrobe_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        done_data   = '0;

        unique case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d     = BUSY_D;
                    d_gnt_d     = 1'b1;
                    m_req_d     = 1'b1;
                    m_rw_d      = bus.d_rw;
                    // Byte enables only mean something on writes.
                    m_wstrobe_d = bus.d_rw ? bus.d_wstrobe : 4'b0000;
                    m_addr_d    = bus.d_addr;
                    m_wdata_d   = bus.d_wdata;
                    tmo_d       = '0;
                    if (bus.if_req)
                        streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                    else
                        streak_d = '0;
                end else if (bus.if_req) begin
                    state_d     = BUSY_I;
                    if_gnt_d    = 1'b1;
                    m_req_d     = 1'b1;
                    m_rw_d      = 1'b0;
                    m_wstrobe_d = 4'b0000;
                    m_addr_d    = bus.if_addr;
                    m_wdata_d   = '0;
                    tmo_d       = '0;
                    streak_d    = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                // An ack on the last allowed cycle still counts as success.
                if (bus.m_ack || (tmo_q == TMO_LAST)) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    if (bus.m_ack) begin
                        done_data = m_rw_q ? 32'h0 : bus.m_rdata;
                    end else begin
                        done_data = ERR_DATA;
                        bus_err_d = 1'b1;
                    end
                    if (state_q == BUSY_I) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = done_data;
                    end else begin
                        d_rvalid_d  = 1'b1;
                        d_rdata_d   = done_data;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            RESP: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tmo_q       <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            m_req_q     <= 1'b0;
            m_rw_q      <= 1'b0;
            m_wstrobe_q <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            m_req_q     <= m_req_d;
            m_rw_q      <= m_rw_d;
            m_wstrobe_q <= m_wstrobe_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.m_req     = m_req_q;
    assign bus.m_rw      = m_rw_q;
    assign bus.m_wstrobe = m_wstrobe_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Cycle-by-cycle vector table for the single-transaction cases, then
//   hand-written sequences for contention, timeout and reset mid-operation.
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int TMO        = 8;

    logic clk;
    logic nreset;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_rw;
        logic [3:0]  d_wstrobe;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ack;
        logic [31:0] m_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_if_rvalid;
        logic        e_d_rvalid;
        logic        e_bus_err;
        logic        e_m_req;
        logic        e_m_rw;
        logic [3:0]  e_m_wstrobe;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"},    32'(bus.if_gnt),    0);
        chk({tag, "_d_gnt"},     32'(bus.d_gnt),     0);
        chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 0);
        chk({tag, "_d_rvalid"},  32'(bus.d_rvalid),  0);
        chk({tag, "_bus_err"},   32'(bus.bus_err),   0);
        chk({tag, "_m_req"},     32'(bus.m_req),     0);
        chk({tag, "_m_rw"},      32'(bus.m_rw),      0);
        chk({tag, "_m_wstrobe"}, 32'(bus.m_wstrobe), 0);
        chk({tag, "_m_addr"},    bus.m_addr,         0);
        chk({tag, "_m_wdata"},   bus.m_wdata,        0);
        chk({tag, "_if_rdata"},  bus.if_rdata,       0);
        chk({tag, "_d_rdata"},   bus.d_rdata,        0);
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_rw = 0;
        bus.d_wstrobe = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.m_ack = 0; bus.m_rdata = 0;
    endtask

    // Both requesters held high; memory acks one cycle after each m_req.
    // Every (MAX_STREAK+1)-th grant must go to IF.
    task automatic run_contention(input string tag, input int n_grants);
        int got = 0;
        int cyc = 0;
        bus.if_req = 1; bus.if_addr = 32'h8000_0100;
        bus.d_req = 1; bus.d_rw = 0; bus.d_wstrobe = 0; bus.d_addr = 32'h500;
        bus.m_ack = 0;
        while (got < n_grants && cyc < 200) begin
            step();
            cyc++;
            chk({tag, "_gnt_overlap"},    32'(bus.if_gnt & bus.d_gnt), 0);
            chk({tag, "_rvalid_overlap"}, 32'(bus.if_rvalid & bus.d_rvalid), 0);
            if (bus.if_gnt || bus.d_gnt) begin
                chk($sformatf("%s_grant%0d_is_if", tag, got), 32'(bus.if_gnt),
                    32'((got % (MAX_STREAK + 1)) == MAX_STREAK));
                got++;
            end
            bus.m_ack = bus.m_req;
        end
        if (got < n_grants) chk({tag, "_grant_count"}, 32'(got), 32'(n_grants));
        bus.if_req = 0; bus.d_req = 0; bus.m_ack = 1;
        step();
        bus.m_ack = 0;
        step();
        step();
    endtask

    initial begin
        int hi;

        // Vectors: inputs applied, one clock, outputs compared.
        //          if_req if_addr        d_req rw strb  d_addr    d_wdata        ack  m_rdata
        //          | ifg dg ifv dv err mreq mrw mstrb m_addr        m_wdata        if_rdata  d_rdata
        vecs[0]  = '{1, 32'h8000_0000, 0, 0, 4'h0, 32'h0,   32'h0,         0, 32'h0,
                     1, 0, 0, 0, 0, 1, 0, 4'h0, 32'h8000_0000, 32'h0,         32'h0,  32'h0};
        vecs[1]  = '{0, 32'h8000_0000, 0, 0, 4'h0, 32'h0,   32'h0,         1, 32'h13,
                     0, 0, 1, 0, 0, 0, 0, 4'h0, 32'h8000_0000, 32'h0,         32'h13, 32'h0};
        vecs[2]  = '{0, 32'h0,         0, 0, 4'h0, 32'h0,   32'h0,         0, 32'h0,
                     0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h8000_0000, 32'h0,         32'h13, 32'h0};
        vecs[3]  = '{0, 32'h0,         1, 1, 4'h3, 32'h100, 32'hA5A5_A5A5, 0, 32'h0,
                     0, 1, 0, 0, 0, 1, 1, 4'h3, 32'h100,       32'hA5A5_A5A5, 32'h13, 32'h0};
        vecs[4]  = '{0, 32'h0,         0, 1, 4'h3, 32'h100, 32'hA5A5_A5A5, 1, 32'h1234_5678,
                     0, 0, 0, 1, 0, 0, 1, 4'h3, 32'h100,       32'hA5A5_A5A5, 32'h13, 32'h0};
        vecs[5]  = '{0, 32'h0,         0, 0, 4'h0, 32'h0,   32'h0,         0, 32'h0,
                     0, 0, 0, 0, 0, 0, 1, 4'h3, 32'h100,       32'hA5A5_A5A5, 32'h13, 32'h0};
        vecs[6]  = '{0, 32'h0,         0, 0, 4'h0, 32'h0,   32'h0,         1, 32'hFFFF_FFFF,
                     0, 0, 0, 0, 0, 0, 1, 4'h3, 32'h100,       32'hA5A5_A5A5, 32'h13, 32'h0};
        vecs[7]  = '{0, 32'h0,         0, 0, 4'h0, 32'h0,   32'h0,         0, 32'h0,
                     0, 0, 0, 0, 0, 0, 1, 4'h3, 32'h100,       32'hA5A5_A5A5, 32'h13, 32'h0};
        vecs[8]  = '{0, 32'h0,         1, 0, 4'hF, 32'h200, 32'h0,         0, 32'h0,
                     0, 1, 0, 0, 0, 1, 0, 4'h0, 32'h200,       32'h0,         32'h13, 32'h0};
        vecs[9]  = '{0, 32'h0,         0, 0, 4'h0, 32'h200, 32'h0,         1, 32'hCAFE_F00D,
                     0, 0, 0, 1, 0, 0, 0, 4'h0, 32'h200,       32'h0,         32'h13, 32'hCAFE_F00D};
        vecs[10] = '{0, 32'h0,         0, 0, 4'h0, 32'h0,   32'h0,         0, 32'h0,
                     0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h200,       32'h0,         32'h13, 32'hCAFE_F00D};

        // Reset state
        nreset = 0;
        idle_inputs();
        #3;
        chk_all_zero("reset");
        step();
        step();
        nreset = 1;

        // Table: lone fetch, data write, ack while idle, data read
        for (int i = 0; i < 11; i++) begin
            bus.if_req    = vecs[i].if_req;
            bus.if_addr   = vecs[i].if_addr;
            bus.d_req     = vecs[i].d_req;
            bus.d_rw      = vecs[i].d_rw;
            bus.d_wstrobe = vecs[i].d_wstrobe;
            bus.d_addr    = vecs[i].d_addr;
            bus.d_wdata   = vecs[i].d_wdata;
            bus.m_ack     = vecs[i].m_ack;
            bus.m_rdata   = vecs[i].m_rdata;
            step();
            chk($sformatf("v%0d_if_gnt", i),    32'(bus.if_gnt),    32'(vecs[i].e_if_gnt));
            chk($sformatf("v%0d_d_gnt", i),     32'(bus.d_gnt),     32'(vecs[i].e_d_gnt));
            chk($sformatf("v%0d_if_rvalid", i), 32'(bus.if_rvalid), 32'(vecs[i].e_if_rvalid));
            chk($sformatf("v%0d_d_rvalid", i),  32'(bus.d_rvalid),  32'(vecs[i].e_d_rvalid));
            chk($sformatf("v%0d_bus_err", i),   32'(bus.bus_err),   32'(vecs[i].e_bus_err));
            chk($sformatf("v%0d_m_req", i),     32'(bus.m_req),     32'(vecs[i].e_m_req));
            chk($sformatf("v%0d_m_rw", i),      32'(bus.m_rw),      32'(vecs[i].e_m_rw));
            chk($sformatf("v%0d_m_wstrobe", i), 32'(bus.m_wstrobe), 32'(vecs[i].e_m_wstrobe));
            chk($sformatf("v%0d_m_addr", i),    bus.m_addr,         vecs[i].e_m_addr);
            chk($sformatf("v%0d_m_wdata", i),   bus.m_wdata,        vecs[i].e_m_wdata);
            chk($sformatf("v%0d_if_rdata", i),  bus.if_rdata,       vecs[i].e_if_rdata);
            chk($sformatf("v%0d_d_rdata", i),   bus.d_rdata,        vecs[i].e_d_rdata);
        end
        idle_inputs();

        // Contention: D,D,D,D,IF,D,D,D,D,IF
        run_contention("cont", 10);

        // Timeout on a data read with no ack
        bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h300; bus.m_ack = 0;
        step();
        chk("to_gnt", 32'(bus.d_gnt), 1);
        bus.d_req = 0;
        hi = 0;
        for (int i = 0; i < 40 && bus.m_req; i++) begin
            hi++;
            step();
        end
        chk("to_mreq_cycles", 32'(hi), 32'(TMO));
        chk("to_d_rvalid", 32'(bus.d_rvalid), 1);
        chk("to_bus_err", 32'(bus.bus_err), 1);
        chk("to_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        chk("to_if_rvalid", 32'(bus.if_rvalid), 0);
        step();
        chk("to_err_pulse", 32'(bus.bus_err), 0);
        chk("to_rvalid_pulse", 32'(bus.d_rvalid), 0);

        // Normal read after the timeout
        bus.d_req = 1; bus.d_addr = 32'h304;
        step();
        chk("post_to_gnt", 32'(bus.d_gnt), 1);
        chk("post_to_m_addr", bus.m_addr, 32'h304);
        bus.d_req = 0; bus.m_ack = 1; bus.m_rdata = 32'h55;
        step();
        chk("post_to_rvalid", 32'(bus.d_rvalid), 1);
        chk("post_to_bus_err", 32'(bus.bus_err), 0);
        chk("post_to_rdata", bus.d_rdata, 32'h55);
        bus.m_ack = 0;
        step();
        step();

        // Reset in the middle of a data write (streak bumped to 1 first)
        bus.if_req = 1; bus.if_addr = 32'h8000_0200;
        bus.d_req = 1; bus.d_rw = 1; bus.d_wstrobe = 4'hF;
        bus.d_addr = 32'h400; bus.d_wdata = 32'h1111_2222;
        step();
        chk("rst_pre_d_gnt", 32'(bus.d_gnt), 1);
        chk("rst_pre_m_req", 32'(bus.m_req), 1);
        idle_inputs();
        #2;
        nreset = 0;
        #1;
        chk_all_zero("rst_async");
        bus.m_ack = 1; bus.m_rdata = 32'h7777_7777;
        step();
        nreset = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rst_stray_ack%0d_d_rvalid", i),  32'(bus.d_rvalid),  0);
            chk($sformatf("rst_stray_ack%0d_if_rvalid", i), 32'(bus.if_rvalid), 0);
            chk($sformatf("rst_stray_ack%0d_m_req", i),     32'(bus.m_req),     0);
        end
        bus.m_ack = 0;
        step();

        // Streak restarted from 0: four D grants before IF
        run_contention("post_rst", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
